batch_chain_dispatcher: RTL and testbench

//  Read-side drain engine for the request buffer. On start it freezes buffer writes and snapshots num_requests.
//  It walks entries in index order; each unissued entry is issued, then its row-hit chain (chain_next) is followed to the end.

---
 rtl/batch_chain_dispatcher_pkg.sv | 30 +++
 rtl/batch_chain_dispatcher.sv | 180 ++++++++++++++++++
 tb/tb_batch_chain_dispatcher.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/batch_chain_dispatcher_pkg.sv
// Shared widths, state encoding and request payload for the batch chain dispatcher.
package batch_chain_dispatcher_pkg;

   localparam int unsigned MAX_REQUESTS     = 8;
   localparam int unsigned REQUEST_ID_WIDTH = $clog2(MAX_REQUESTS);
   localparam int unsigned PTR_WIDTH        = REQUEST_ID_WIDTH + 1;
   localparam int unsigned BANK_GROUP_WIDTH = 2;
   localparam int unsigned BANK_WIDTH       = 2;
   localparam int unsigned ROW_WIDTH        = 14;
   localparam int unsigned COLUMN_WIDTH     = 10;
   localparam int unsigned DISP_STATE_WIDTH = 3;

   typedef enum logic [DISP_STATE_WIDTH-1:0] {
      DISP_IDLE    = 3'd0,
      DISP_FREEZE  = 3'd1,
      DISP_SCAN    = 3'd2,
      DISP_FETCH   = 3'd3,
      DISP_CAPTURE = 3'd4,
      DISP_ISSUE   = 3'd5,
      DISP_CLEAR   = 3'd6
   } disp_state_t;

   typedef struct packed {
      logic [BANK_GROUP_WIDTH-1:0] bank_group;
      logic [BANK_WIDTH-1:0]       bank;
      logic [ROW_WIDTH-1:0]        row;
      logic [COLUMN_WIDTH-1:0]     column;
   } req_fields_t;

endpackage

// File: rtl/batch_chain_dispatcher.sv
// Drains the request buffer in index order, following each entry's row-hit chain,
// and empties the buffer with a batch_clear pulse once every entry has been issued.
module batch_chain_dispatcher
   import batch_chain_dispatcher_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   output logic                        busy,
   output logic                        buf_batch_start,
   output logic                        batch_clear,
   output logic                        batch_done,
   input  logic [REQUEST_ID_WIDTH-1:0] num_requests,
   output logic [REQUEST_ID_WIDTH-1:0] rd_addr,
   input  logic [BANK_GROUP_WIDTH-1:0] rd_bank_group,
   input  logic [BANK_WIDTH-1:0]       rd_bank,
   input  logic [ROW_WIDTH-1:0]        rd_row,
   input  logic [COLUMN_WIDTH-1:0]     rd_column,
   input  logic [REQUEST_ID_WIDTH-1:0] rd_chain_next,
   input  logic                        rd_chain_valid,
   output logic                        cmd_valid,
   input  logic                        cmd_ready,
   output logic [BANK_GROUP_WIDTH-1:0] cmd_bank_group,
   output logic [BANK_WIDTH-1:0]       cmd_bank,
   output logic [ROW_WIDTH-1:0]        cmd_row,
   output logic [COLUMN_WIDTH-1:0]     cmd_column,
   output logic [REQUEST_ID_WIDTH-1:0] cmd_id,
   output logic                        cmd_row_hit,
   output logic                        chain_err
);

   disp_state_t                 state, state_nxt;
   logic [MAX_REQUESTS-1:0]     issued, issued_nxt;
   logic [PTR_WIDTH-1:0]        scan_ptr, scan_ptr_nxt;
   logic [PTR_WIDTH-1:0]        count, count_nxt;
   logic [REQUEST_ID_WIDTH-1:0] rd_addr_q, rd_addr_nxt;
   req_fields_t                 cmd_q, cmd_nxt;
   logic [REQUEST_ID_WIDTH-1:0] cmd_id_q, cmd_id_nxt;
   logic [REQUEST_ID_WIDTH-1:0] nxt_q, nxt_nxt;
   logic                        nxt_v_q, nxt_v_nxt;
   logic                        cmd_valid_q, cmd_valid_nxt;
   logic                        row_hit_q, row_hit_nxt;
   logic                        chain_err_q, chain_err_nxt;
   logic                        busy_q, busy_nxt;
   logic                        clear_q, clear_nxt;
   logic                        handshake;
   logic                        link_good;

   assign handshake = cmd_valid_q && cmd_ready;

   // The issued check also stops any chain that loops back on itself.
   assign link_good = nxt_v_q && (PTR_WIDTH'(nxt_q) < count) &&
                      !issued[nxt_q] && (nxt_q != cmd_id_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= DISP_IDLE;
         issued      <= '0;
         scan_ptr    <= '0;
         count       <= '0;
         rd_addr_q   <= '0;
         cmd_q       <= '0;
         cmd_id_q    <= '0;
         nxt_q       <= '0;
         nxt_v_q     <= 1'b0;
         cmd_valid_q <= 1'b0;
         row_hit_q   <= 1'b0;
         chain_err_q <= 1'b0;
         busy_q      <= 1'b0;
         clear_q     <= 1'b0;
      end else begin
         state       <= state_nxt;
         issued      <= issued_nxt;
         scan_ptr    <= scan_ptr_nxt;
         count       <= count_nxt;
         rd_addr_q   <= rd_addr_nxt;
         cmd_q       <= cmd_nxt;
         cmd_id_q    <= cmd_id_nxt;
         nxt_q       <= nxt_nxt;
         nxt_v_q     <= nxt_v_nxt;
         cmd_valid_q <= cmd_valid_nxt;
         row_hit_q   <= row_hit_nxt;
         chain_err_q <= chain_err_nxt;
         busy_q      <= busy_nxt;
         clear_q     <= clear_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      issued_nxt    = issued;
      scan_ptr_nxt  = scan_ptr;
      count_nxt     = count;
      rd_addr_nxt   = rd_addr_q;
      cmd_nxt       = cmd_q;
      cmd_id_nxt    = cmd_id_q;
      nxt_nxt       = nxt_q;
      nxt_v_nxt     = nxt_v_q;
      cmd_valid_nxt = cmd_valid_q;
      row_hit_nxt   = row_hit_q;
      chain_err_nxt = 1'b0;

      case (state)
         DISP_IDLE: begin
            if (start) state_nxt = DISP_FREEZE;
         end
         // One cycle late so a write accepted alongside start is in the snapshot.
         DISP_FREEZE: begin
            count_nxt    = PTR_WIDTH'(num_requests);
            issued_nxt   = '0;
            scan_ptr_nxt = '0;
            state_nxt    = DISP_SCAN;
         end
         DISP_SCAN: begin
            if (scan_ptr == count) begin
               state_nxt = DISP_CLEAR;
            end else if (issued[scan_ptr[REQUEST_ID_WIDTH-1:0]]) begin
               scan_ptr_nxt = scan_ptr + PTR_WIDTH'(1);
            end else begin
               rd_addr_nxt = scan_ptr[REQUEST_ID_WIDTH-1:0];
               row_hit_nxt = 1'b0;
               state_nxt   = DISP_FETCH;
            end
         end
         DISP_FETCH: begin
            state_nxt = DISP_CAPTURE;
         end
         DISP_CAPTURE: begin
            cmd_nxt.bank_group = rd_bank_group;
            cmd_nxt.bank       = rd_bank;
            cmd_nxt.row        = rd_row;
            cmd_nxt.column     = rd_column;
            cmd_id_nxt         = rd_addr_q;
            nxt_nxt            = rd_chain_next;
            nxt_v_nxt          = rd_chain_valid;
            cmd_valid_nxt      = 1'b1;
            state_nxt          = DISP_ISSUE;
         end
         DISP_ISSUE: begin
            if (handshake) begin
               issued_nxt[cmd_id_q] = 1'b1;
               cmd_valid_nxt        = 1'b0;
               if (link_good) begin
                  rd_addr_nxt = nxt_q;
                  row_hit_nxt = 1'b1;
                  state_nxt   = DISP_FETCH;
               end else begin
                  chain_err_nxt = nxt_v_q;
                  scan_ptr_nxt  = scan_ptr + PTR_WIDTH'(1);
                  state_nxt     = DISP_SCAN;
               end
            end
         end
         DISP_CLEAR: begin
            state_nxt = DISP_IDLE;
         end
         default: begin
            state_nxt = DISP_IDLE;
         end
      endcase

      busy_nxt  = (state_nxt != DISP_IDLE);
      clear_nxt = (state_nxt == DISP_CLEAR);
   end

   assign busy            = busy_q;
   assign buf_batch_start = busy_q;
   assign batch_clear     = clear_q;
   assign batch_done      = clear_q;
   assign rd_addr         = rd_addr_q;
   assign cmd_valid       = cmd_valid_q;
   assign cmd_bank_group  = cmd_q.bank_group;
   assign cmd_bank        = cmd_q.bank;
   assign cmd_row         = cmd_q.row;
   assign cmd_column      = cmd_q.column;
   assign cmd_id          = cmd_id_q;
   assign cmd_row_hit     = row_hit_q;
   assign chain_err       = chain_err_q;

endmodule

// File: tb/tb_batch_chain_dispatcher.sv
// Scoreboard bench: a small request-buffer model feeds the dispatcher; a monitor checks every handshake.
module tb_batch_chain_dispatcher;
   import batch_chain_dispatcher_pkg::*;

   typedef struct packed {
      logic [BANK_GROUP_WIDTH-1:0] bg;
      logic [BANK_WIDTH-1:0]       bk;
      logic [ROW_WIDTH-1:0]        row;
      logic [COLUMN_WIDTH-1:0]     col;
      logic [REQUEST_ID_WIDTH-1:0] cn;
      logic                        cv;
   } ent_t;

   typedef struct packed {
      logic [REQUEST_ID_WIDTH-1:0] id;
      logic                        hit;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic cmd_ready = 1'b1;
   logic busy, buf_batch_start, batch_clear, batch_done;
   logic [REQUEST_ID_WIDTH-1:0] num_requests, rd_addr, cmd_id;
   logic cmd_valid, cmd_row_hit, chain_err;
   logic [BANK_GROUP_WIDTH-1:0] cmd_bank_group;
   logic [BANK_WIDTH-1:0]       cmd_bank;
   logic [ROW_WIDTH-1:0]        cmd_row;
   logic [COLUMN_WIDTH-1:0]     cmd_column;

   // request buffer model: append-only writes, 1-cycle registered read
   ent_t mem [MAX_REQUESTS];
   ent_t rd_q = '0;
   ent_t wr_ent = '0;
   logic wr_en = 1'b0;
   int   num_req = 0;

   int tests = 0;
   int fails = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      rd_q <= mem[rd_addr];
      if (batch_clear) num_req <= 0;
      else if (wr_en && !buf_batch_start && num_req < int'(MAX_REQUESTS)) begin
         mem[REQUEST_ID_WIDTH'(num_req)] <= wr_ent;
         num_req <= num_req + 1;
      end
   end

   assign num_requests = REQUEST_ID_WIDTH'(num_req);

   batch_chain_dispatcher dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy),
      .buf_batch_start(buf_batch_start), .batch_clear(batch_clear), .batch_done(batch_done),
      .num_requests(num_requests), .rd_addr(rd_addr),
      .rd_bank_group(rd_q.bg), .rd_bank(rd_q.bk), .rd_row(rd_q.row), .rd_column(rd_q.col),
      .rd_chain_next(rd_q.cn), .rd_chain_valid(rd_q.cv),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_bank_group(cmd_bank_group), .cmd_bank(cmd_bank), .cmd_row(cmd_row),
      .cmd_column(cmd_column), .cmd_id(cmd_id), .cmd_row_hit(cmd_row_hit), .chain_err(chain_err)
   );

   function automatic ent_t mk(input int i, input logic [REQUEST_ID_WIDTH-1:0] cn, input logic cv);
      ent_t e;
      e.bg  = BANK_GROUP_WIDTH'(i);
      e.bk  = BANK_WIDTH'(i + 1);
      e.row = ROW_WIDTH'(256 + i * 37);
      e.col = COLUMN_WIDTH'(i * 3 + 5);
      e.cn  = cn;
      e.cv  = cv;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic chk_fields(input string tag, input int id);
      ent_t e;
      e = mk(id, '0, 1'b0);
      chk({tag, " bank_group"}, 32'(cmd_bank_group), 32'(e.bg));
      chk({tag, " bank"},       32'(cmd_bank),       32'(e.bk));
      chk({tag, " row"},        32'(cmd_row),        32'(e.row));
      chk({tag, " column"},     32'(cmd_column),     32'(e.col));
   endtask

   // scoreboard monitor: sampled after stimulus settles, before the next rising edge
   always @(negedge clk) begin
      #2;
      if (!rst && cmd_valid && cmd_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_cmd: got id %0d, expected no command", cmd_id);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("cmd_id", 32'(cmd_id), 32'(e.id));
            chk("cmd_row_hit", 32'(cmd_row_hit), 32'(e.hit));
            chk_fields("cmd", int'(e.id));
         end
      end
   end

   task automatic wr(input int i, input logic [REQUEST_ID_WIDTH-1:0] cn, input logic cv);
      wr_ent = mk(i, cn, cv);
      wr_en  = 1'b1;
      @(negedge clk);
      wr_en  = 1'b0;
   endtask

   task automatic push(input int id, input logic hit);
      exp_t e;
      e.id  = REQUEST_ID_WIDTH'(id);
      e.hit = hit;
      exp_q.push_back(e);
   endtask

   // Pulses start (optionally with a simultaneous buffer write) and waits for batch_clear.
   task automatic drain(input bit with_wr, output int first_v, output int clr_c, output int errs);
      first_v = 0;
      clr_c   = 0;
      errs    = 0;
      start   = 1'b1;
      wr_en   = with_wr;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         start = 1'b0;
         wr_en = 1'b0;
         if (cmd_valid && first_v == 0) first_v = c;
         if (chain_err) errs++;
         if (batch_clear) begin
            clr_c = c;
            chk("batch_done_with_clear", 32'(batch_done), 32'd1);
            break;
         end
      end
      if (clr_c == 0) chk("batch_clear_timeout", 32'd0, 32'd1);
      @(negedge clk);
      chk("single_batch_clear", 32'(batch_clear), 32'd0);
      chk("idle_after_clear", 32'(busy), 32'd0);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      int fv, cc, ne, waited;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset cmd_valid", 32'(cmd_valid), 32'd0);
      chk("reset batch_clear", 32'(batch_clear), 32'd0);
      chk("reset rd_addr", 32'(rd_addr), 32'd0);
      chk("reset cmd_id", 32'(cmd_id), 32'd0);
      @(negedge clk);

      // T1: empty batch
      start = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         start = 1'b0;
         chk($sformatf("t1 busy c%0d", c), 32'(busy), 32'(c <= 3));
         chk($sformatf("t1 buf_batch_start c%0d", c), 32'(buf_batch_start), 32'(c <= 3));
         chk($sformatf("t1 batch_clear c%0d", c), 32'(batch_clear), 32'(c == 3));
         chk($sformatf("t1 cmd_valid c%0d", c), 32'(cmd_valid), 32'd0);
      end

      // T2: four independent entries
      for (int i = 0; i < 4; i++) wr(i, '0, 1'b0);
      for (int i = 0; i < 4; i++) push(i, 1'b0);
      drain(1'b0, fv, cc, ne);
      chk("t2 first_valid_latency", 32'(fv), 32'd5);
      chk("t2 clear_cycle", 32'(cc), 32'd19);
      chk("t2 chain_err", 32'(ne), 32'd0);

      // T3: chain 0->2->3, entry 1 alone
      wr(0, 3'd2, 1'b1);
      wr(1, 3'd0, 1'b0);
      wr(2, 3'd3, 1'b1);
      wr(3, 3'd0, 1'b0);
      push(0, 1'b0); push(2, 1'b1); push(3, 1'b1); push(1, 1'b0);
      drain(1'b0, fv, cc, ne);
      chk("t3 clear_cycle", 32'(cc), 32'd19);
      chk("t3 chain_err", 32'(ne), 32'd0);

      // T4: backpressure holds the command stable
      wr(0, '0, 1'b0);
      wr(1, '0, 1'b0);
      cmd_ready = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waited = 0;
      while (!cmd_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      chk("t4 valid_seen", 32'(cmd_valid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("t4 hold valid k%0d", k), 32'(cmd_valid), 32'd1);
         chk($sformatf("t4 hold id k%0d", k), 32'(cmd_id), 32'd0);
         chk_fields($sformatf("t4 hold k%0d", k), 0);
         @(negedge clk);
      end
      push(0, 1'b0); push(1, 1'b0);
      cmd_ready = 1'b1;
      waited = 0;
      while (!batch_clear && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      chk("t4 batch_clear", 32'(batch_clear), 32'd1);
      @(negedge clk);
      chk("t4 scoreboard_empty", 32'(exp_q.size()), 32'd0);
      exp_q.delete();

      // T5: broken links (back-pointer to issued entry, out of range)
      wr(0, '0, 1'b0);
      wr(1, 3'd0, 1'b1);
      wr(2, 3'd7, 1'b1);
      wr(3, '0, 1'b0);
      for (int i = 0; i < 4; i++) push(i, 1'b0);
      drain(1'b0, fv, cc, ne);
      chk("t5 chain_err_count", 32'(ne), 32'd2);
      chk("t5 clear_cycle", 32'(cc), 32'd19);

      // T6: reset mid-issue aborts, then a fresh drain
      for (int i = 0; i < 3; i++) wr(i, '0, 1'b0);
      cmd_ready = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waited = 0;
      while (!cmd_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      chk("t6 in_issue", 32'(cmd_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6 rst busy", 32'(busy), 32'd0);
      chk("t6 rst cmd_valid", 32'(cmd_valid), 32'd0);
      chk("t6 rst batch_clear", 32'(batch_clear), 32'd0);
      chk("t6 rst rd_addr", 32'(rd_addr), 32'd0);
      chk("t6 rst cmd_id", 32'(cmd_id), 32'd0);
      @(negedge clk);
      chk("t6 no batch_clear", 32'(batch_clear), 32'd0);
      cmd_ready = 1'b1;
      for (int i = 0; i < 3; i++) push(i, 1'b0);
      drain(1'b0, fv, cc, ne);
      chk("t6 clear_cycle", 32'(cc), 32'd15);

      // T7: write accepted in the start cycle is part of the batch
      wr(0, '0, 1'b0);
      wr(1, '0, 1'b0);
      wr_ent = mk(2, '0, 1'b0);
      for (int i = 0; i < 3; i++) push(i, 1'b0);
      drain(1'b1, fv, cc, ne);
      chk("t7 clear_cycle", 32'(cc), 32'd15);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
